// File: rtl/onehot_decoder_3to8_stream.sv
// Streaming 3-to-8 decoder: queues 3-bit codes in a small FIFO and drives the
// matching one-hot word on dec_out for HOLD_CYCLES cycles per code.
module onehot_decoder_3to8_stream #(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2:0]                 in_code,
  output logic [7:0]                 dec_out,
  output logic                       out_valid,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       busy
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef enum logic {S_IDLE, S_DRIVE} state_t;

  logic [2:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  state_t        r_state;
  logic [7:0]    r_dec;
  logic          r_out_valid;
  logic [HW-1:0] r_hold;

  state_t        w_state_next;
  logic          w_pop;
  logic          w_push;
  logic          w_nonempty;
  logic [2:0]    w_head;
  logic [7:0]    w_dec_next;
  logic          w_out_valid_next;
  logic [HW-1:0] w_hold_next;

  assign w_nonempty = (r_count != '0);
  assign w_head     = r_mem[r_rd_ptr];

  // A full FIFO refuses pushes even when the FSM pops in the same edge.
  assign in_ready   = (r_count < FULL_COUNT) && !rst;
  assign w_push     = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_code;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_dec       <= '0;
      r_out_valid <= 1'b0;
      r_hold      <= '0;
    end else begin
      r_state     <= w_state_next;
      r_dec       <= w_dec_next;
      r_out_valid <= w_out_valid_next;
      r_hold      <= w_hold_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_nonempty) begin
          w_pop        = 1'b1;
          w_state_next = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (r_hold == '0) begin
          if (w_nonempty) begin
            w_pop = 1'b1;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Reloading on the final hold cycle keeps consecutive codes gap-free.
  always_comb begin
    w_dec_next       = r_dec;
    w_out_valid_next = r_out_valid;
    w_hold_next      = r_hold;
    if (w_pop) begin
      w_dec_next       = 8'h01 << w_head;
      w_out_valid_next = 1'b1;
      w_hold_next      = HOLD_LOAD;
    end else if (r_state == S_IDLE) begin
      w_dec_next       = '0;
      w_out_valid_next = 1'b0;
    end else if (r_hold != '0) begin
      w_hold_next = r_hold - HW'(1);
    end else begin
      w_dec_next       = '0;
      w_out_valid_next = 1'b0;
    end
  end

  assign dec_out    = r_dec;
  assign out_valid  = r_out_valid;
  assign fifo_count = r_count;
  assign busy       = r_out_valid || w_nonempty;

endmodule

// File: tb/tb_onehot_decoder_3to8_stream.sv
// Directed bench for the streaming 3-to-8 decoder: reset, single code, sweep,
// full/stall, mid-run reset and a priority-encoder round trip at HOLD_CYCLES=1.
module tb_onehot_decoder_3to8_stream;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_code;
  logic [7:0] dec_out;
  logic       out_valid;
  logic [2:0] fifo_count;
  logic       busy;

  logic       in1_valid;
  logic       in1_ready;
  logic [2:0] in1_code;
  logic [7:0] dec1_out;
  logic       out1_valid;
  logic [2:0] fifo1_count;
  logic       busy1;

  int n_checks = 0;
  int n_errors = 0;

  logic       mon_en = 1'b0;
  logic [7:0] obs[$];
  logic       full_seen;

  onehot_decoder_3to8_stream #(.DEPTH(4), .HOLD_CYCLES(3)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .dec_out(dec_out), .out_valid(out_valid),
    .fifo_count(fifo_count), .busy(busy)
  );

  onehot_decoder_3to8_stream #(.DEPTH(4), .HOLD_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in1_valid), .in_ready(in1_ready),
    .in_code(in1_code), .dec_out(dec1_out), .out_valid(out1_valid),
    .fifo_count(fifo1_count), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (mon_en) obs.push_back(dec_out);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds the code valid until accepted; also checks in_ready drops at full.
  task automatic send(input logic [2:0] code);
    int   waited = 0;
    logic acc = 1'b0;
    in_valid = 1'b1;
    in_code  = code;
    while (!acc && waited < 50) begin
      if (!full_seen && (!in_ready || fifo_count == 3'd4)) begin
        check("full_ready", {28'd0, in_ready, fifo_count}, {28'd0, 1'b0, 3'd4});
        full_seen = 1'b1;
      end
      acc = in_ready;
      tick();
      waited++;
    end
    in_valid = 1'b0;
    if (!acc) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 300) begin
      tick();
      n++;
    end
    check("idle_reached", {31'd0, busy}, 32'd0);
  endtask

  // Compares the recorded dec_out stream against codes held 3 cycles each.
  task automatic check_stream(input string name, input int codes[8], input int ncodes);
    int f = -1;
    for (int i = 0; i < obs.size(); i++) begin
      if (f < 0 && obs[i] != 8'h00) f = i;
    end
    if (f < 0 || f + ncodes * 3 >= obs.size()) begin
      check({name, "_len"}, obs.size(), ncodes * 3);
      return;
    end
    for (int i = 0; i < ncodes * 3; i++) begin
      logic [7:0] e;
      e = 8'h01 << codes[i / 3];
      check($sformatf("%s_%0d", name, i), {24'd0, obs[f + i]}, {24'd0, e});
    end
    check({name, "_tail"}, {24'd0, obs[f + ncodes * 3]}, 32'd0);
  endtask

  function automatic logic [2:0] penc(input logic [7:0] v);
    logic [2:0] r = 3'd0;
    for (int i = 0; i < 8; i++) if (v[i]) r = 3'(i);
    return r;
  endfunction

  initial begin
    int sweep[8]  = '{0, 1, 2, 3, 4, 5, 6, 7};
    int stall[8]  = '{6, 1, 4, 2, 7, 0, 0, 0};
    logic [7:0] rt_in[3]  = '{8'b10010000, 8'b00001001, 8'b00100100};
    logic [7:0] rt_exp[3] = '{8'b10000000, 8'b00001000, 8'b00100000};
    logic seen;

    rst = 1'b1; in_valid = 1'b1; in_code = 3'd3;
    in1_valid = 1'b0; in1_code = 3'd0;
    full_seen = 1'b0;

    // Reset with in_valid held high
    for (int c = 0; c < 2; c++) begin
      tick();
      check("rst_dec", {24'd0, dec_out}, 32'h00);
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      check("rst_count", {29'd0, fifo_count}, 32'd0);
      check("rst_ready", {31'd0, in_ready}, 32'd0);
    end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check("ready_after_rst", {31'd0, in_ready}, 32'd1);

    // Single code 5
    in_valid = 1'b1; in_code = 3'd5;
    tick();
    in_valid = 1'b0;
    check("single_count", {29'd0, fifo_count}, 32'd1);
    check("single_nobypass", {31'd0, out_valid}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("single_dec_%0d", c), {24'd0, dec_out}, 32'h20);
      check($sformatf("single_valid_%0d", c), {31'd0, out_valid}, 32'd1);
    end
    tick();
    check("single_dec_end", {24'd0, dec_out}, 32'h00);
    check("single_busy_end", {31'd0, busy}, 32'd0);

    // Sweep 0..7 back-to-back
    obs.delete(); mon_en = 1'b1; full_seen = 1'b0;
    for (int k = 0; k < 8; k++) send(3'(sweep[k]));
    check("sweep_full_seen", {31'd0, full_seen}, 32'd1);
    wait_idle();
    tick();
    mon_en = 1'b0;
    check_stream("sweep", sweep, 8);

    // Full/stall with five-plus codes
    obs.delete(); mon_en = 1'b1; full_seen = 1'b0;
    for (int k = 0; k < 5; k++) send(3'(stall[k]));
    wait_idle();
    tick();
    mon_en = 1'b0;
    check_stream("stall", stall, 5);

    // Reset during DRIVE with two codes queued
    send(3'd2); send(3'd5); send(3'd6);
    check("mid_pre_count", {29'd0, fifo_count}, 32'd2);
    check("mid_pre_valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    tick();
    check("mid_dec", {24'd0, dec_out}, 32'h00);
    check("mid_count", {29'd0, fifo_count}, 32'd0);
    check("mid_valid", {31'd0, out_valid}, 32'd0);
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      seen = seen | out_valid | busy;
    end
    check("mid_discarded", {31'd0, seen}, 32'd0);

    // Round trip through a priority encoder, HOLD_CYCLES=1
    for (int k = 0; k < 3; k++) begin
      in1_valid = 1'b1;
      in1_code  = penc(rt_in[k]);
      check($sformatf("rt_ready_%0d", k), {31'd0, in1_ready}, 32'd1);
      tick();
      if (k > 0) check($sformatf("rt_dec_%0d", k - 1), {24'd0, dec1_out}, {24'd0, rt_exp[k - 1]});
    end
    in1_valid = 1'b0;
    tick();
    check("rt_dec_2", {24'd0, dec1_out}, {24'd0, rt_exp[2]});
    tick();
    check("rt_dec_end", {24'd0, dec1_out}, 32'h00);
    check("rt_valid_end", {31'd0, out1_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/onehot_decoder_3to8_stream.md
Name: onehot_decoder_3to8_stream

Overview:
- Streaming 3-to-8 decoder: the inverse of the 8-to-3 priority encoder.
- Accepts 3-bit codes over a valid/ready handshake and buffers them in a small FIFO.
- Drives the matching one-hot line on an 8-bit output for a programmable number of cycles per code.
- Sits downstream of the priority encoder, converting granted indices back into one-hot select/enable lines.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- HOLD_CYCLES, 3, cycles each decoded one-hot word stays asserted; >= 1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  in_code is valid this cycle
- in_ready  output  1  block can accept a code this cycle
- in_code  input  3  index to decode, 0..7
- dec_out  output  8  one-hot decoded word, or 0 when idle
- out_valid  output  1  dec_out carries a decoded code
- fifo_count  output  $clog2(DEPTH+1)  number of queued codes
- busy  output  1  out_valid or fifo_count != 0

Behaviour:
- Reset:
  - Synchronous; takes priority over all other activity.
  - After any edge with rst=1: dec_out=0, out_valid=0, fifo_count=0, FSM=IDLE, hold counter=0, FIFO pointers=0.
  - Queued codes are discarded.
  - in_ready=0 while rst=1.
- Input handshake:
  - Transfer occurs on an edge where in_valid=1 and in_ready=1.
  - in_ready = (fifo_count < DEPTH) and not rst; derived from registered state only.
  - When full, a push is refused even if a pop happens in the same cycle.
  - in_code must be held stable by the source while in_valid=1 and in_ready=0.
- FIFO:
  - Circular buffer with wrap-around pointers.
  - Simultaneous push and pop leaves fifo_count unchanged.
  - Pop is performed only by the FSM.
- FSM states IDLE, DRIVE:
  - IDLE: if fifo_count != 0, pop head, register dec_out <= 8'b1 << code, out_valid <= 1, hold_cnt <= HOLD_CYCLES-1, go to DRIVE. Otherwise dec_out=0, out_valid=0.
  - DRIVE with hold_cnt != 0: decrement hold_cnt; dec_out is unchanged.
  - DRIVE with hold_cnt == 0 and FIFO non-empty: pop the next code and reload dec_out and hold_cnt in the same edge. This gives back-to-back output with no idle gap.
  - DRIVE with hold_cnt == 0 and FIFO empty: dec_out <= 0, out_valid <= 0, go to IDLE.
- Latency:
  - A code accepted at edge N into an empty, idle block appears on dec_out after edge N+1.
  - It is held for exactly HOLD_CYCLES cycles.
  - No bypass path exists.
- Output invariants:
  - dec_out is always 0 or exactly one-hot.
  - out_valid=1 iff dec_out != 0.
  - Outputs are registered, with no combinational path from in_* to dec_out.
- A code pushed into an empty FIFO in the same edge that IDLE samples is not visible until the next edge; the FIFO has no read-during-write forwarding.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1 -> dec_out=8'h00, out_valid=0, fifo_count=0, in_ready=0 during reset. in_ready=1 on the first cycle after rst falls.
- Single code: push 3'b101 at edge N -> dec_out=8'b00100000, out_valid=1 during cycles N+1..N+3. dec_out=0 and busy=0 from N+4.
- Sweep: push codes 0..7 back-to-back -> dec_out steps 8'h01,02,04,...,80, each for 3 cycles with no gap. in_ready drops once fifo_count=4, and all 8 codes are emitted in order.
- Full/stall: with DEPTH=4 full and a 5th code held valid -> in_ready=0 and in_code stable. The code is accepted only after a pop, with no loss or duplication.
- Reset mid-operation: assert rst during DRIVE with fifo_count=2 -> after that edge dec_out=0, fifo_count=0, FSM=IDLE. Discarded codes never appear.
- Round-trip with priority_encoder_8to3 and HOLD_CYCLES=1:
  - Feed the encoder with en_in values 8'b10010000, 8'b00001001, 8'b00100100.
  - Expected dec_out sequence: 8'b10000000, 8'b00001000, 8'b00100000, on consecutive cycles.
